vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two users:
  - the VGA display fetch, which has fixed priority and is real-time;
  - one game-logic writer, using a req/ack handshake.
- Driven by the 640x480 sync timing (pix_x, pix_y, video_on, ref_tick).
- Framebuffer holds 80x60 cells; each cell is 8x8 pixels and stores one DATA_W colour word.
- Sits between the sync generator, framebuffer RAM, and the colour output stage.

Parameters:
- H_START, 144, first active pix_x
- V_START, 35, first active pix_y
- COLS, 80, cells per row
- ROWS, 60, cell rows
- ADDR_W, 13, RAM address width
- DATA_W, 8, cell colour width

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-high reset
- pix_x  in  10  current horizontal count (0..799)
- pix_y  in  10  current vertical count (0..524)
- video_on  in  1  active display region
- ref_tick  in  1  one-cycle pulse at pix_x=799, pix_y=524
- wr_req  in  1  writer request; held until wr_ack
- wr_addr  in  ADDR_W  cell index, row*COLS+col
- wr_data  in  DATA_W  cell colour
- wr_ack  out  1  one-cycle write grant
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; 1-cycle latency after mem_en
- pix_data  out  DATA_W  colour of the current cell
- synced  out  1  display fetch enabled

Behaviour:
- Reset (asynchronous, active-high) clears all outputs and internal state:
  - mem_en, mem_we, wr_ack, synced = 0
  - mem_addr, mem_wdata, pix_data = 0
  - state = SYNC_WAIT
  - col_cnt = 0, row_base = 0
- All outputs are registered.
- States:
  - SYNC_WAIT: no display fetches; writes allowed. Moves to IDLE on ref_tick; synced=1 from the next cycle.
  - IDLE: no RAM access this cycle.
  - DISP: display read issued.
  - WRITE: write issued.
- Display fetch slot: a cycle where all of the following hold:
  - synced = 1;
  - V_START <= pix_y < V_START+480;
  - pix_x == H_START + 8*col_cnt - 3, with col_cnt < COLS.
- Display fetch timing (S = H_START + 8*col_cnt):
  - decided in the cycle pix_x = S-3;
  - mem_en=1, mem_we=0, mem_addr=row_base+col_cnt during cycle S-2;
  - mem_rdata valid during S-1;
  - pix_data registered so it is valid for pix_x = S..S+7;
  - col_cnt increments after the slot.
- pix_data holds its last value outside the active area; the downstream stage gates it with video_on.
- Counters:
  - col_cnt clears when pix_x==799.
  - row_base += COLS when pix_x==799 and (pix_y-V_START)[2:0]==7, for active pix_y only.
  - row_base and col_cnt clear on ref_tick.
  - Address arithmetic uses adders only, no multiplier.
- Write arbitration:
  - With wr_req=1 in a non-display-slot cycle, the next cycle has mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, and wr_ack=1 for exactly that cycle.
  - The writer drops or changes the request after seeing wr_ack.
  - Back-to-back writes are allowed: a write at most every 2 cycles (req must be re-evaluated after ack).
- Simultaneous display slot and wr_req: display wins. The write is granted at the first following eligible cycle; wr_req stays held and no data is lost.
- wr_addr >= COLS*ROWS: wr_ack still pulses, mem_en stays 0, and the write is dropped.
- Reset mid-frame: returns to SYNC_WAIT. No fetch until the next ref_tick, so a partial frame never uses stale row_base.
- Worst-case writer latency: 2 cycles, or the VBLANK wait when the optional feature is enabled.

Optional Feature:
- VGA_FB_VBLANK_WR_ONLY_EN
  - Defined: writes are granted only when pix_y < V_START or pix_y >= V_START+480 (tear-free update). Requests during active lines wait for blanking.
  - Undefined: writes are granted in any non-display-slot cycle.

Test Plan:
- Reset, run until first ref_tick → synced=0 and mem_en=0 before the tick; synced=1 after it; first fetch at pix_y=35, pix_x=141 with mem_addr=0.
- Preload RAM cell 81 = 8'hA5 → pix_data=8'hA5 for pix_x 152..159 on pix_y 43..50; mem_addr=81 issued in cycle pix_x=150.
- wr_req with wr_addr=5, wr_data=8'h3C, asserted exactly at pix_y=35, pix_x=141 → display read of addr 0 first; write to addr 5 with wr_ack in the following cycle; readback shows 8'h3C.
- wr_addr=4800 → one wr_ack pulse, no mem_en, RAM unchanged.
- Assert rst at pix_y=200 → all outputs 0 and synced=0; fetches resume only at pix_y=35 of the next frame with correct addresses (row 20 → addr 1600 at pix_y=195).
- Macro defined, wr_req at pix_y=100 → wr_ack not before pix_y=515; undefined → wr_ack within 2 cycles.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter: real-time VGA cell fetch over game-logic writes
// Optional build macro VGA_FB_VBLANK_WR_ONLY_EN: grant writes only outside the active lines.
module vga_fb_arbiter #(
    parameter int H_START = 144,
    parameter int V_START = 35,
    parameter int COLS    = 80,
    parameter int ROWS    = 60,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              video_on,
    input  logic              ref_tick,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              synced
);

    localparam int                CW        = $clog2(COLS + 1);
    localparam logic [CW-1:0]     COLS_C    = CW'(COLS);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS     = ADDR_W'(COLS * ROWS);
    localparam logic [9:0]        X_FIRST   = 10'(H_START - 3);
    localparam logic [9:0]        Y_FIRST   = 10'(V_START);
    localparam logic [9:0]        Y_END     = 10'(V_START + 480);
    localparam logic [9:0]        LINE_LAST = 10'd799;

    typedef enum logic [1:0] {SYNC_WAIT, IDLE, DISP, WRITE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_cnt_q, col_cnt_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic                synced_q, synced_d;
    logic                rd_pend_q;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                wr_ack_q, wr_ack_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   pix_data_q, pix_data_d;

    logic                y_active;
    logic [2:0]          y_phase;
    logic [9:0]          slot_x;
    logic                line_end;
    logic                fetch_slot;
    logic                wr_window;
    logic                wr_grant;
    logic                addr_ok;
    logic                unused_video_on;

    assign unused_video_on = video_on;

    assign y_active   = (pix_y >= Y_FIRST) && (pix_y < Y_END);
    assign y_phase    = 3'(pix_y - Y_FIRST);
    assign line_end   = (pix_x == LINE_LAST);
    // Slot for cell col_cnt sits three pixels ahead of its first pixel.
    assign slot_x     = X_FIRST + 10'({col_cnt_q, 3'b000});
    assign fetch_slot = synced_q && y_active && (col_cnt_q < COLS_C) && (pix_x == slot_x);
    assign addr_ok    = (wr_addr < CELLS);

`ifdef VGA_FB_VBLANK_WR_ONLY_EN
    assign wr_window = !y_active;
`else
    assign wr_window = 1'b1;
`endif

    assign wr_grant = wr_req && !fetch_slot && wr_window;
    assign synced_d = synced_q || ref_tick;

    always_comb begin
        col_cnt_d  = col_cnt_q;
        row_base_d = row_base_q;
        if (ref_tick) begin
            col_cnt_d  = '0;
            row_base_d = '0;
        end else begin
            if (line_end) begin
                col_cnt_d = '0;
            end else if (fetch_slot) begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
            if (line_end && y_active && (y_phase == 3'd7)) begin
                row_base_d = row_base_q + ROW_STEP;
            end
        end
    end

    // A write cycle never chains into another grant: the held request is stale until the writer saw wr_ack.
    always_comb begin
        state_d = synced_d ? IDLE : SYNC_WAIT;
        case (state_q)
            WRITE: begin
                if (fetch_slot) begin
                    state_d = DISP;
                end
            end
            default: begin
                if (fetch_slot) begin
                    state_d = DISP;
                end else if (wr_grant) begin
                    state_d = WRITE;
                end
            end
        endcase
    end

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        wr_ack_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_d)
            DISP: begin
                mem_en_d   = 1'b1;
                mem_addr_d = row_base_q + ADDR_W'(col_cnt_q);
            end
            WRITE: begin
                wr_ack_d = 1'b1;
                if (addr_ok) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                end
            end
            default: begin
                mem_en_d = 1'b0;
            end
        endcase
        pix_data_d = rd_pend_q ? mem_rdata : pix_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC_WAIT;
            col_cnt_q   <= '0;
            row_base_q  <= '0;
            synced_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            row_base_q  <= row_base_d;
            synced_q    <= synced_d;
            rd_pend_q   <= (state_q == DISP);
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            wr_ack_q    <= wr_ack_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_data  = pix_data_q;
    assign synced    = synced_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard bench for vga_fb_arbiter with RAM and sync-timing models
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pix_x, pix_y;
    logic        video_on, ref_tick, wr_req;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack, mem_en, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, pix_data;
    logic        synced;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
        .ref_tick(ref_tick), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_data(pix_data), .synced(synced)
    );

    typedef struct { int addr; int x; int y; } rd_t;
    typedef struct { int addr; int data; int exp_cyc; } wr_t;
    typedef struct { int y; int x; int addr; int data; } trig_t;

    rd_t   rd_q[$];
    wr_t   wr_q[$];
    wr_t   pend_q[$];
    trig_t trig_q[$];

    logic [7:0] ram     [0:8191];
    logic [7:0] exp_mem [0:8191];

    int n_chk = 0, n_pass = 0, cyc = 0;
    int rst_x = -1, rst_y = -1;
    int cap_addr, cap_data;
    bit synced_m, prev_ref, ack_seen, cap_en, cap_we, init_rst, line_full;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (pix_y=%0d pix_x=%0d)", tag, got, exp, pix_y, pix_x);
    endtask

    function automatic bit y_act(input int y);
        return (y >= 35) && (y < 515);
    endfunction

    function automatic bit is_slot(input int x, input int y);
        return synced_m && y_act(y) && (x >= 141) && (x <= 773) && (((x - 141) % 8) == 0);
    endfunction

    task automatic monitor();
        int x, y;
        rd_t r;
        wr_t w;
        bit ok;
        x = int'(pix_x);
        y = int'(pix_y);
        check("synced", int'(synced), int'(synced_m));
        if (rst) begin
            check("rst_mem_en", int'(mem_en), 0);
            check("rst_mem_we", int'(mem_we), 0);
            check("rst_wr_ack", int'(wr_ack), 0);
            check("rst_mem_addr", int'(mem_addr), 0);
            check("rst_mem_wdata", int'(mem_wdata), 0);
            check("rst_pix_data", int'(pix_data), 0);
        end
        if (mem_en && !mem_we) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", int'(mem_addr), -1);
            end else begin
                r = rd_q.pop_front();
                check("rd_addr", int'(mem_addr), r.addr);
                check("rd_x", x, r.x);
                check("rd_y", y, r.y);
            end
        end
        if (wr_ack || (mem_en && mem_we)) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", int'(mem_addr), -1);
            end else begin
                w = wr_q.pop_front();
                ok = (w.addr < 4800);
                check("wr_ack", int'(wr_ack), 1);
                check("wr_en", int'(mem_en), int'(ok));
                check("wr_we", int'(mem_we), int'(ok));
                if (ok) begin
                    check("wr_addr", int'(mem_addr), w.addr);
                    check("wr_data", int'(mem_wdata), w.data);
                    exp_mem[w.addr] = 8'(w.data);
                end
                if (w.exp_cyc >= 0) check("wr_lat", cyc, w.exp_cyc);
                else check("wr_vblank", int'(!y_act(y)), 1);
            end
        end
        if (line_full && synced_m && y_act(y) && (x >= 144) && (x <= 783) &&
            ((((x - 144) % 8) == 0) || (((x - 144) % 8) == 7)))
            check("pix", int'(pix_data), int'(exp_mem[((y - 35) / 8) * 80 + (x - 144) / 8]));
        cap_en   = mem_en;
        cap_we   = mem_we;
        cap_addr = int'(mem_addr);
        cap_data = int'(mem_wdata);
        ack_seen = wr_ack;
    endtask

    task automatic tick(input int x, input int y);
        wr_t   e;
        trig_t t;
        @(posedge clk);
        #1;
        cyc++;
        if (cap_en) begin
            if (cap_we) ram[cap_addr] = 8'(cap_data);
            else mem_rdata = ram[cap_addr];
        end
        if (prev_ref) synced_m = 1'b1;
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        ref_tick = (x == 799) && (y == 524);
        prev_ref = ref_tick;
        video_on = (x >= 144) && (x < 784) && y_act(y);
        if (init_rst || (x == rst_x && y == rst_y)) begin
            rst      = 1'b1;
            synced_m = 1'b0;
            prev_ref = 1'b0;
            rd_q.delete();
        end else begin
            rst = 1'b0;
        end
        if (ack_seen) begin
            ack_seen = 1'b0;
            wr_req   = 1'b0;
            if (pend_q.size() > 0) e = pend_q.pop_front();
        end
        while (trig_q.size() > 0 && trig_q[0].y == y && trig_q[0].x == x) begin
            t = trig_q.pop_front();
            e.addr = t.addr;
            e.data = t.data;
            e.exp_cyc = 0;
            pend_q.push_back(e);
        end
        if (!wr_req && pend_q.size() > 0) begin
            e = pend_q[0];
            wr_req  = 1'b1;
            wr_addr = 13'(e.addr);
            wr_data = 8'(e.data);
            e.exp_cyc = is_slot(x, y) ? cyc + 2 : cyc + 1;
`ifdef VGA_FB_VBLANK_WR_ONLY_EN
            if (y_act(y)) e.exp_cyc = -1;
`endif
            wr_q.push_back(e);
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic run_line(input int y, input bit full);
        rd_t r;
        int  x0;
        x0 = full ? 0 : ((y >= 515) ? 790 : 799);
        line_full = full;
        if (full && synced_m && y_act(y)) begin
            for (int c = 0; c < 80; c++) begin
                r.addr = ((y - 35) / 8) * 80 + c;
                r.x = 142 + 8 * c;
                r.y = y;
                rd_q.push_back(r);
            end
        end
        for (int x = x0; x <= 799; x++) tick(x, y);
    endtask

    function automatic bit is_full(input int f, input int y);
        case (f)
            0: return y == 40;
            1: return (y == 35) || (y == 43) || (y == 50) || (y == 60) || (y == 131) ||
                      (y == 195) || (y == 200) || (y == 201);
            default: return (y == 35) || (y == 195);
        endcase
    endfunction

    task automatic run_frame(input int f, input int last_y);
        for (int y = 0; y <= last_y; y++) run_line(y, is_full(f, y));
    endtask

    task automatic add_trig(input int y, input int x, input int addr, input int data);
        trig_t t;
        t.y = y; t.x = x; t.addr = addr; t.data = data;
        trig_q.push_back(t);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            ram[i]     = 8'(i * 37 + 11);
            exp_mem[i] = 8'(i * 37 + 11);
        end
        rst = 1'b1; pix_x = '0; pix_y = '0; video_on = 1'b0; ref_tick = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
        add_trig(40, 500, 81, 8'hA5);
        add_trig(35, 141, 5, 8'h3C);
        add_trig(60, 300, 4800, 8'h99);
        add_trig(100, 799, 1000, 8'h77);
        add_trig(131, 600, 2000, 8'h11);
        add_trig(131, 600, 2001, 8'h22);
        init_rst = 1'b1;
        tick(0, 0);
        tick(1, 0);
        init_rst = 1'b0;
        run_frame(0, 524);
        rst_x = 400;
        rst_y = 200;
        run_frame(1, 524);
        rst_x = -1;
        rst_y = -1;
        run_frame(2, 200);
        check("rd_queue_left", rd_q.size(), 0);
        check("wr_queue_left", wr_q.size(), 0);
        check("writer_left", pend_q.size() + trig_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
